booth4_serial_multiplier: RTL and testbench

Parametrised radix-4 Booth multiplier with a built-in controller and datapath. Operands arrive over a narrow valid/ready byte-serial bus. It computes one Booth digit per cycle and returns the full 2N-bit product through a valid/ready output handshake. It supersedes the fixed 16-bit, two-beat, signed-only multiplier with three-cycle iterations. It sits between the board I/O front end (switch/UART beat source) and the display/result sink.

---
 rtl/booth4_serial_multiplier_if.sv | 26 ++
 rtl/booth4_serial_multiplier.sv | 147 ++++++++++++++
 tb/tb_booth4_serial_multiplier.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/booth4_serial_multiplier_if.sv
// Byte-serial operand bus and result handshake for the radix-4 Booth multiplier.
// The source side (beat source / result sink) uses the master modport; the multiplier uses slave.
interface booth4_serial_multiplier_if #(
    parameter int N    = 16,
    parameter int IN_W = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            is_signed;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  product;
    logic            ovf;
    logic            busy;

    modport master (
        output in_valid, in_data, is_signed, out_ready,
        input  in_ready, out_valid, product, ovf, busy
    );

    modport slave (
        input  in_valid, in_data, is_signed, out_ready,
        output in_ready, out_valid, product, ovf, busy
    );
endinterface

// File: rtl/booth4_serial_multiplier.sv
// Radix-4 Booth multiplier: byte-serial operand load, one Booth digit per clock, full 2N-bit result.
// state    | meaning
// LOAD_A   | accepting multiplicand beats, LSB beat first; first beat latches signed mode
// LOAD_X   | accepting multiplier beats; last beat seeds the accumulator
// CALC     | one Booth digit per clock (N/2 signed, N/2+1 unsigned)
// DONE     | result valid and held until the sink accepts it
module booth4_serial_multiplier #(
    parameter int N    = 16,
    parameter int IN_W = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    booth4_serial_multiplier_if.slave bus
);
    localparam int BEATS = N / IN_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int M     = N + 3;
    localparam int DIG_W = $clog2(N / 2 + 2);

    localparam logic [1:0] S_LOAD_A = 2'd0;
    localparam logic [1:0] S_LOAD_X = 2'd1;
    localparam logic [1:0] S_CALC   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_x;
    logic              r_mode;
    logic signed [N+1:0] r_p;
    logic [M-1:0]      r_m;
    logic [DIG_W-1:0]  r_dig;
    logic [2*N-1:0]    r_product;
    logic              r_ovf;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_last_beat;
    logic [N-1:0]      w_a_next;
    logic [N-1:0]      w_x_next;
    logic signed [N+1:0] w_a_ext;
    logic signed [N+1:0] w_addend;
    logic signed [N+1:0] w_sum;
    logic signed [N+M+1:0] w_full;
    logic [2*N-1:0]    w_prod;
    logic              w_ovf;

    assign bus.in_ready  = (r_state == S_LOAD_A) || (r_state == S_LOAD_X);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.product   = r_product;
    assign bus.ovf       = r_ovf;
    assign bus.busy      = (r_state != S_LOAD_A) || (r_cnt != '0);

    assign w_in_fire   = bus.in_valid & bus.in_ready;
    assign w_out_fire  = bus.out_valid & bus.out_ready;
    assign w_last_beat = (r_cnt == LAST_BEAT);

    always_comb begin
        w_a_next = r_a;
        w_x_next = r_x;
        w_a_next[int'(r_cnt) * IN_W +: IN_W] = bus.in_data;
        w_x_next[int'(r_cnt) * IN_W +: IN_W] = bus.in_data;
    end

    // N+2 bits keeps -2A of the most negative signed operand from wrapping.
    assign w_a_ext = r_mode ? {{2{r_a[N-1]}}, r_a} : {2'b00, r_a};

    always_comb begin
        w_addend = '0;
        case (r_m[2:0])
            3'b001, 3'b010: w_addend = w_a_ext;
            3'b011:         w_addend = {w_a_ext[N:0], 1'b0};
            3'b100:         w_addend = -{w_a_ext[N:0], 1'b0};
            3'b101, 3'b110: w_addend = -w_a_ext;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum  = r_p + w_addend;
    assign w_full = $signed({w_sum, r_m}) >>> 2;

    // After the last digit the product sits above the leftover multiplier bits:
    // three of them in signed mode, one in unsigned mode (two extra shifts consumed).
    assign w_prod = r_mode ? w_full[3 +: 2*N] : w_full[1 +: 2*N];
    assign w_ovf  = r_mode ? !((&w_prod[2*N-1:N-1]) || !(|w_prod[2*N-1:N-1]))
                           : (|w_prod[2*N-1:N]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_LOAD_A;
            r_cnt     <= '0;
            r_a       <= '0;
            r_x       <= '0;
            r_mode    <= 1'b0;
            r_p       <= '0;
            r_m       <= '0;
            r_dig     <= '0;
            r_product <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD_A: begin
                    if (w_in_fire) begin
                        r_a <= w_a_next;
                        if (r_cnt == '0) r_mode <= bus.is_signed;
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_state <= S_LOAD_X;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_X: begin
                    if (w_in_fire) begin
                        r_x <= w_x_next;
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_p     <= '0;
                            r_m     <= {(r_mode ? {2{w_x_next[N-1]}} : 2'b00), w_x_next, 1'b0};
                            r_dig   <= r_mode ? DIG_W'(N / 2 - 1) : DIG_W'(N / 2);
                            r_state <= S_CALC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_p <= w_full[N+M+1:M];
                    r_m <= w_full[M-1:0];
                    if (r_dig == '0) begin
                        r_product <= w_prod;
                        r_ovf     <= w_ovf;
                        r_state   <= S_DONE;
                    end else begin
                        r_dig <= r_dig - 1'b1;
                    end
                end
                default: begin
                    if (w_out_fire) r_state <= S_LOAD_A;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth4_serial_multiplier.sv
// Bench for booth4_serial_multiplier at N=16, IN_W=8: directed corner cases plus random
// operands, compared against plain integer multiplication.
module tb_booth4_serial_multiplier;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    booth4_serial_multiplier_if #(.N(16), .IN_W(8)) bus ();

    booth4_serial_multiplier #(.N(16), .IN_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint ref_value(input logic [15:0] a, input logic [15:0] x, input logic sgn);
        logic signed [15:0] sa;
        logic signed [15:0] sx;
        sa = a;
        sx = x;
        if (sgn) return longint'(sa) * longint'(sx);
        return longint'({16'h0, a}) * longint'({16'h0, x});
    endfunction

    function automatic logic ref_ovf(input longint p, input logic sgn);
        if (sgn) return (p < -32768) || (p > 32767);
        return p >= 65536;
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic s, input int gap);
        int t;
        t = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.is_signed = s;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("in_ready_beat", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hxx;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] x, input logic sgn,
                         input logic flip, input int gap, input int hold);
        longint     p;
        logic [31:0] ep;
        logic        eo;
        int          d;
        int          lat;
        p  = ref_value(a, x, sgn);
        ep = p[31:0];
        eo = ref_ovf(p, sgn);
        d  = sgn ? 8 : 9;
        send_beat(a[7:0], sgn, gap);
        chk("busy_after_a0", bus.busy, 1);
        send_beat(a[15:8], sgn ^ flip, gap);
        send_beat(x[7:0], sgn ^ flip, gap);
        send_beat(x[15:8], sgn ^ flip, gap);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.out_valid) chk("in_ready_calc", bus.in_ready, 0);
        end while (!bus.out_valid && lat < 40);
        chk("latency", lat, d);
        chk("product", bus.product, ep);
        chk("ovf", bus.ovf, eo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_product", bus.product, ep);
            chk("hold_ovf", bus.ovf, eo);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_busy", bus.busy, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("valid_drop", bus.out_valid, 0);
        chk("in_ready_after", bus.in_ready, 1);
        chk("busy_after", bus.busy, 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_product", bus.product, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rx;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_product", bus.product, 0);
        chk("reset_ovf", bus.ovf, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_in_ready", bus.in_ready, 1);

        do_op(16'h0003, 16'h0005, 1'b1, 1'b0, 0, 0);
        do_op(16'hFFFD, 16'h0007, 1'b1, 1'b0, 0, 0);
        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, 0);
        do_op(16'h0100, 16'h00FF, 1'b0, 1'b0, 0, 0);
        do_op(16'h7FFF, 16'h8000, 1'b1, 1'b0, 0, 1);
        do_op(16'h8000, 16'hFFFF, 1'b0, 1'b0, 0, 0);

        // backpressure: gaps between beats and a stalled sink
        do_op(16'h1357, 16'hF00D, 1'b1, 1'b0, 1, 5);

        // is_signed toggled after the first A beat must not change the mode
        do_op(16'hFFFF, 16'h0002, 1'b1, 1'b1, 0, 0);
        do_op(16'hFFFF, 16'h0002, 1'b0, 1'b1, 0, 0);

        // reset mid-CALC, then after a single A beat
        send_beat(8'h34, 1'b1, 0);
        send_beat(8'h12, 1'b1, 0);
        send_beat(8'h10, 1'b1, 0);
        send_beat(8'h00, 1'b1, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        pulse_rst();
        send_beat(8'hAA, 1'b0, 0);
        pulse_rst();
        do_op(16'h1234, 16'h0010, 1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rx = 16'($urandom);
            if (i % 8 == 0) ra = 16'h8000;
            if (i % 8 == 1) rx = 16'hFFFF;
            do_op(ra, rx, 1'($urandom), 1'b0, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
